// File: rtl/signal_frame_quantizer.sv
// signal_frame_quantizer
//   Quantizes a stream of signed samples to signed bytes (round-half-up,
//   saturate to [-128,127]) and collects them in a 256-entry frame buffer.
//   A full frame is presented to the byte sender for exactly 256 cycles.
//   The buffer is frozen for that window, and then the block refills.
//
// Ports
//   clk         in   single clock, posedge
//   rst_n       in   asynchronous active-low reset
//   inSample    in   IN_W-bit signed sample
//   inValidFlg  in   inSample valid this cycle
//   inRdyFlg    out  sample accepted this cycle (state FILL)
//   outbytes    out  256 x 8-bit frame buffer
//   startFlg    out  frame presented to sender (state HOLD)
//   frameCnt    out  frames completed, wraps
//   dropCnt     out  samples offered while not ready, saturates at 255
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting samples; each valid sample written at wrIdx
// HOLD  | frame frozen and presented for 256 cycles; offered samples dropped

module signal_frame_quantizer #(
    parameter int IN_W  = 16,
    parameter int SHIFT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] inSample,
    input  logic            inValidFlg,
    output logic            inRdyFlg,
    output logic [7:0]      outbytes [0:255],
    output logic            startFlg,
    output logic [7:0]      frameCnt,
    output logic [7:0]      dropCnt
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // One extra bit of headroom so adding the rounding constant cannot overflow.
    localparam logic signed [IN_W:0] C_HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] C_MAX  = 127;
    localparam logic signed [IN_W:0] C_MIN  = -128;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_wr_idx;
    logic [7:0]        r_hold_cnt;
    logic [7:0]        r_frame_cnt;
    logic [7:0]        r_drop_cnt;
    logic [7:0]        r_buf [0:255];

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shr;
    logic [7:0]           w_q;
    logic                 w_wr_en;
    logic                 w_last_wr;
    logic                 w_drop;

    // Quantizer
    assign w_ext = $signed({inSample[IN_W-1], inSample});
    assign w_sum = w_ext + C_HALF;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_q = w_shr[7:0];
        if (w_shr > C_MAX) begin
            w_q = 8'h7F;
        end else if (w_shr < C_MIN) begin
            w_q = 8'h80;
        end
    end

    // Next-state and strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_last_wr   = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_FILL: begin
                w_wr_en = inValidFlg;
                if (inValidFlg && (r_wr_idx == 8'hFF)) begin
                    w_last_wr   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_drop = inValidFlg;
                if (r_hold_cnt == 8'hFF) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_hold_cnt  <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_idx <= r_wr_idx + 8'd1;   // 255 wraps to 0 on the last write
            end
            if (w_last_wr) begin
                r_hold_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Frame buffer; only written in FILL, so it is frozen through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_buf[r_wr_idx] <= w_q;
        end
    end

    assign outbytes = r_buf;
    assign inRdyFlg = (r_state == S_FILL);
    assign startFlg = (r_state == S_HOLD);
    assign frameCnt = r_frame_cnt;
    assign dropCnt  = r_drop_cnt;

endmodule
